// File: rtl/prio_dec.sv
// prio_dec: turns a bit index back into a one-hot vector and a fill mask through a two-stage valid/ready pipeline.
// Optional fill-mask datapath is built only when PRIO_DEC_MASK_EN is defined; otherwise mask reads zero.
module prio_dec #(
    parameter int WIDTH_LOG = 4,
    localparam int WIDTH = 1 << WIDTH_LOG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] onehot,
    output logic [WIDTH-1:0] mask,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [8:0]     LIMIT = 9'(WIDTH);

    logic             advance;
    logic             s1_valid_q, s1_valid_d;
    logic [7:0]       s1_idx_q, s1_idx_d;
    logic             s1_err_q, s1_err_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] onehot_q, onehot_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [WIDTH:0]   onehot_full;
    logic             unused_top;

`ifdef PRIO_DEC_MASK_EN
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH:0]   mask_full;

    // Shifts stay WIDTH+1 bits wide so idx=HI yields all ones without wrap.
    assign mask_full  = ((ONE_W << 1) << s1_idx_q) - ONE_W;
    assign unused_top = onehot_full[WIDTH] ^ mask_full[WIDTH];
    assign mask       = mask_q;
`else
    assign unused_top = onehot_full[WIDTH];
    assign mask       = '0;
`endif

    assign onehot_full = ONE_W << s1_idx_q;
    assign in_ready    = advance || !s1_valid_q;
    assign out_valid   = out_valid_q;
    assign onehot      = onehot_q;
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;

    always_comb begin
        advance     = !out_valid_q || out_ready;
        s1_valid_d  = s1_valid_q;
        s1_idx_d    = s1_idx_q;
        s1_err_d    = s1_err_q;
        out_valid_d = out_valid_q;
        onehot_d    = onehot_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
`ifdef PRIO_DEC_MASK_EN
        mask_d      = mask_q;
`endif

        // Range check uses all 8 index bits before any truncation.
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_idx_d = idx;
                s1_err_d = ({1'b0, idx} >= LIMIT);
            end
        end

        if (advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                err_d    = s1_err_q;
                onehot_d = s1_err_q ? '0 : onehot_full[WIDTH-1:0];
`ifdef PRIO_DEC_MASK_EN
                mask_d   = s1_err_q ? '0 : mask_full[WIDTH-1:0];
`endif
            end
        end

        if (out_valid_q && out_ready && err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            onehot_q    <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
`ifdef PRIO_DEC_MASK_EN
            mask_q      <= '0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_idx_q    <= s1_idx_d;
            s1_err_q    <= s1_err_d;
            out_valid_q <= out_valid_d;
            onehot_q    <= onehot_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
`ifdef PRIO_DEC_MASK_EN
            mask_q      <= mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_prio_dec.sv
// tb_prio_dec: scoreboard bench for prio_dec; a driver pushes reference results, a monitor pops them on output transfers.
// Mask checks are compiled in only when PRIO_DEC_MASK_EN is defined.
module tb_prio_dec;

    localparam int WIDTH_LOG = 4;
    localparam int WIDTH     = 1 << WIDTH_LOG;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       idx;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] onehot;
    logic [WIDTH-1:0] mask;
    logic             err;
    logic [7:0]       err_cnt;

    always #5 clk = ~clk;

    prio_dec #(.WIDTH_LOG(WIDTH_LOG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .idx(idx),
        .out_valid(out_valid), .out_ready(out_ready), .onehot(onehot), .mask(mask),
        .err(err), .err_cnt(err_cnt)
    );

    typedef struct {
        int               v;
        logic [WIDTH-1:0] onehot;
        logic [WIDTH-1:0] mask;
        logic             err;
        logic [WIDTH-1:0] x;
    } exp_t;

    exp_t sb[$];
    int   acc_cyc[$];
    int   pop_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   model_err_cnt = 0;
    bit   rand_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Reference model: bit i of onehot is set iff i==v, bit i of mask iff i<=v.
    function automatic exp_t refModel(input int v, input logic [WIDTH-1:0] x);
        exp_t e;
        e.v      = v;
        e.err    = (v >= WIDTH);
        e.x      = x;
        e.onehot = '0;
        e.mask   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            e.onehot[i] = !e.err && (i == v);
            e.mask[i]   = !e.err && (i <= v);
        end
        return e;
    endfunction

    function automatic int encodeMsb(input logic [WIDTH-1:0] x);
        for (int i = WIDTH - 1; i >= 0; i--) if (x[i]) return i;
        return 0;
    endfunction

    function automatic logic [WIDTH-1:0] highBit(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r = '0;
        r[encodeMsb(x)] = 1'b1;
        return r;
    endfunction

    task automatic applyStimulus(input int v, input logic [WIDTH-1:0] x = '0);
        int k;
        in_valid = 1'b1;
        idx      = 8'(v);
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 500) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            sb.push_back(refModel(v, x));
            acc_cyc.push_back(cyc);
            last_acc = cyc;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goIdle();
        in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitDrain();
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) break;
        end
        if (k == 2000) begin
            checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: output-hold check, input-stall assertion and scoreboard pop.
    exp_t             mon_e;
    logic             hold_pend = 1'b0;
    logic [WIDTH-1:0] hold_oh, hold_mask;
    logic             hold_err;
    logic             in_stall = 1'b0;
    logic [7:0]       stall_idx;

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
            in_stall  = 1'b0;
        end else begin
            if (in_stall) assert (in_valid && idx == stall_idx) else $error("[TB] input changed while stalled");
            in_stall  = in_valid && !in_ready;
            stall_idx = idx;
            if (hold_pend) begin
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_onehot", 32'(onehot), 32'(hold_oh));
                checkOutput("hold_err", 32'(err), 32'(hold_err));
`ifdef PRIO_DEC_MASK_EN
                checkOutput("hold_mask", 32'(mask), 32'(hold_mask));
`endif
            end
            hold_pend = out_valid && !out_ready;
            hold_oh   = onehot;
            hold_mask = mask;
            hold_err  = err;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput($sformatf("onehot_idx%0d", mon_e.v), 32'(onehot), 32'(mon_e.onehot));
                    checkOutput($sformatf("err_idx%0d", mon_e.v), 32'(err), 32'(mon_e.err));
`ifdef PRIO_DEC_MASK_EN
                    checkOutput($sformatf("mask_idx%0d", mon_e.v), 32'(mask), 32'(mon_e.mask));
`endif
                    if (mon_e.x != '0) begin
                        checkOutput("rt_onehot", 32'(onehot), 32'(highBit(mon_e.x)));
`ifdef PRIO_DEC_MASK_EN
                        checkOutput("rt_cover", 32'(mon_e.x & ~mask), 32'd0);
`endif
                    end
                    pop_cyc.push_back(cyc);
                    if (mon_e.err && model_err_cnt < 255) model_err_cnt++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        logic [WIDTH-1:0] x;
        rst = 1'b1; in_valid = 1'b0; idx = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_onehot", 32'(onehot), 32'd0);
        checkOutput("rst_mask", 32'(mask), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        step(1);

        $display("[TB] single request idx=5");
        out_ready = 1'b1;
        applyStimulus(5);
        goIdle();
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        checkOutput("latency", 32'(cyc - last_acc), 32'd2);
        checkOutput("t1_onehot", 32'(onehot), 32'h0020);
        checkOutput("t1_err", 32'(err), 32'd0);
`ifdef PRIO_DEC_MASK_EN
        checkOutput("t1_mask", 32'(mask), 32'h003F);
`endif
        waitDrain();

        $display("[TB] back-to-back 0,15,7");
        acc_cyc.delete(); pop_cyc.delete();
        applyStimulus(0); applyStimulus(15); applyStimulus(7);
        goIdle();
        waitDrain();
        checkOutput("b2b_pops", 32'(pop_cyc.size()), 32'd3);
        if (pop_cyc.size() == 3 && acc_cyc.size() == 3) begin
            checkOutput("b2b_accept_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
            checkOutput("b2b_accept_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd1);
            checkOutput("b2b_result_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
            checkOutput("b2b_result_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
        end

        $display("[TB] backpressure 3,4,9");
        pop_cyc.delete();
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(3); applyStimulus(4); applyStimulus(9);
                goIdle();
            end
        join_none
        step(5);
        @(negedge clk);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_onehot", 32'(onehot), 32'h0008);
`ifdef PRIO_DEC_MASK_EN
        checkOutput("bp_mask", 32'(mask), 32'h000F);
`endif
        step(1);
        out_ready = 1'b1;
        wait fork;
        waitDrain();
        checkOutput("bp_count", 32'(pop_cyc.size()), 32'd3);

        $display("[TB] out-of-range requests");
        applyStimulus(WIDTH); applyStimulus(255);
        goIdle();
        waitDrain();
        checkOutput("err_cnt_two", 32'(err_cnt), 32'd2);
        for (int i = 0; i < 300; i++) applyStimulus(int'($urandom_range(WIDTH, 255)));
        goIdle();
        waitDrain();
        checkOutput("err_cnt_sat", 32'(err_cnt), 32'd255);
        checkOutput("err_cnt_model", 32'(err_cnt), 32'(model_err_cnt));

        $display("[TB] reset mid-flight");
        out_ready = 1'b0;
        applyStimulus(1); applyStimulus(2);
        goIdle();
        @(negedge clk);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        step(1);
        rst = 1'b1;
        sb.delete();
        model_err_cnt = 0;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step(1);
        out_ready = 1'b1;
        step(6);

        $display("[TB] random round-trip with backpressure");
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        x = WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
                        applyStimulus(encodeMsb(x), x);
                    end else if ($urandom_range(0, 9) == 0) begin
                        applyStimulus(255);
                    end else begin
                        applyStimulus(int'($urandom_range(0, WIDTH + 3)));
                    end
                end
                goIdle();
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        waitDrain();
        checkOutput("rand_err_cnt", 32'(err_cnt), 32'(model_err_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_dec.md
Name: prio_dec

Overview:
- Inverse of the priority encoder: converts a bit index (the 8-bit `msb` format used across the design) back into WIDTH-bit vectors.
- Outputs are a one-hot vector `1 << idx` and a fill mask with bits [idx:0] set.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Sits between the prime-search control logic and the sieve/bitmap datapath; rebuilds candidate masks from encoded positions.

Parameters:
- WIDTH_LOG, 4, log2 of vector width; WIDTH = 1 << WIDTH_LOG, HI = WIDTH - 1; legal range 1..8.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  `idx` holds a request.
- in_ready  output  1  block accepts a request this cycle.
- idx  input  8  bit index, same encoding as the encoder's `msb` output.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- onehot  output  WIDTH  `1 << idx`; all zero when `err`.
- mask  output  WIDTH  bits [idx:0] set, i.e. `(2 << idx) - 1` truncated to WIDTH; all zero when `err`.
- err  output  1  `idx >= WIDTH`.
- err_cnt  output  8  saturating count of accepted out-of-range requests.

Behaviour:
- Reset values:
  - out_valid = 0.
  - onehot, mask, err, err_cnt = 0.
  - Internal stage-valid flags cleared.
  - in_ready = 1 in the cycle after reset deasserts.
- Reset mid-operation drops all in-flight requests; no partial result appears afterwards.
- Handshakes:
  - Transfer when valid && ready at the clock edge.
  - in_valid/idx stay stable while in_valid=1 && in_ready=0. The block does not check this; the bench asserts it.
  - out_valid, onehot, mask and err hold stable while out_valid=1 && out_ready=0.
- Stage 1 (S1):
  - Registers idx.
  - Computes `range_err = (idx >= WIDTH)`. Compare on all 8 bits; never truncate idx before the check.
- Stage 2 (S2), output register:
  - Registers onehot, mask and err from the S1 contents.
  - On err, onehot and mask are forced to zero.
- Latency: a request accepted in cycle N gives out_valid=1 in cycle N+2 when there is no backpressure.
- Throughput: one result per cycle while out_ready=1.
- Flow control (stall-all pipeline, no skid buffer):
  - advance = !out_valid || out_ready.
  - in_ready = advance || !s1_valid.
  - S1 loads when in_ready; S2 loads from S1 when advance.
  - Full: both stages valid and out_ready=0, so in_ready=0.
  - Empty: out_valid=0 and in_ready=1.
- Simultaneous events:
  - An output transfer and an input accept in the same cycle both occur.
  - S2 takes S1 and S1 takes the new idx, with no bubble.
- err_cnt:
  - Increments when an err result transfers on the output (out_valid && out_ready && err).
  - Saturates at 255; never wraps.
- Boundary cases:
  - idx=0: onehot=1, mask=1.
  - idx=HI: onehot=1<<HI, mask all ones.
  - idx=WIDTH: err=1, outputs zero.
  - idx=255: err=1, outputs zero.
- Widths: all shifts are done at WIDTH+1 bits and truncated, so idx=HI produces no overflow artefact in mask.

Optional Feature:
- Macro: PRIO_DEC_MASK_EN.
- Defined: mask is produced as described above.
- Undefined:
  - mask is tied to zero.
  - The mask register and shift logic are not built.
  - onehot, err, err_cnt and the handshake are unchanged.
- The bench checks mask only when PRIO_DEC_MASK_EN is defined.

Test Plan:
- Single request, WIDTH_LOG=4, idx=5, out_ready=1:
  - out_valid rises exactly 2 cycles after accept.
  - onehot=0x0020, mask=0x003F, err=0.
- Back-to-back idx=0,15,7, out_ready held 1:
  - Results on 3 consecutive cycles: (0x0001,0x0001), (0x8000,0xFFFF), (0x0080,0x00FF).
  - in_ready stays 1 throughout.
- Backpressure:
  - Send idx=3,4,9 with out_ready=0 for 5 cycles. in_ready drops after two accepts; the output holds onehot=0x0008, mask=0x000F stable.
  - Release out_ready: results for idx=3, 4, 9 emerge in order with none lost or duplicated.
- Out-of-range:
  - idx=16 and idx=255 give err=1 with onehot=mask=0.
  - err_cnt reads 2.
  - 300 further err requests leave err_cnt=255.
- Reset mid-flight:
  - Assert rst for one cycle while both stages are valid.
  - Next cycle: out_valid=0, err_cnt=0, in_ready=1; no stale result appears later.
- Round-trip with the encoder:
  - Random nonzero x is encoded to msb, msb is fed to prio_dec, and the resulting onehot is compared with x.
  - Required: onehot equals the highest set bit of x, and (x & ~mask) == 0 for all samples.
